// File: rtl/rs_parity_enc_pkg.sv
// Shared constants and types for the GF(256) Reed-Solomon parity encoder.
package rs_parity_enc_pkg;

    // Field polynomial x^8 + x^4 + x^3 + x^2 + 1
    localparam logic [8:0] GF_POLY = 9'h11D;

    // Number of parity symbols appended to each codeword
    localparam int RS_NPAR = 4;

    // Generator g(x) = x^4 + G3*x^3 + G2*x^2 + G1*x + G0
    localparam logic [7:0] G0 = 8'h40;
    localparam logic [7:0] G1 = 8'h78;
    localparam logic [7:0] G2 = 8'h36;
    localparam logic [7:0] G3 = 8'h0F;

    typedef enum logic {
        ST_DATA   = 1'b0,
        ST_PARITY = 1'b1
    } encState_t;

endpackage

// File: rtl/gf256_mult.sv
// Combinational GF(256) multiplier; a constant operand folds to an XOR network.
module gf256_mult
    import rs_parity_enc_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_p
);

    logic [7:0] w_acc;
    logic [7:0] w_shifted;

    // Shift-and-add multiply, reducing by the field polynomial on each doubling
    always_comb begin
        w_acc     = 8'h00;
        w_shifted = i_a;
        for (int i = 0; i < 8; i++) begin
            if (i_b[i]) begin
                w_acc = w_acc ^ w_shifted;
            end
            w_shifted = {w_shifted[6:0], 1'b0} ^ (w_shifted[7] ? GF_POLY[7:0] : 8'h00);
        end
    end

    assign o_p = w_acc;

endmodule

// File: rtl/rs_parity_enc_lfsr4.sv
// Four-stage remainder LFSR dividing the message by g(x); r3 is the next parity out.
module rs_lfsr4
    import rs_parity_enc_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic       i_shift,
    input  logic       i_clear,
    input  logic [7:0] i_sym,
    output logic [7:0] o_r3
);

    logic [7:0] r_r0;
    logic [7:0] r_r1;
    logic [7:0] r_r2;
    logic [7:0] r_r3;
    logic [7:0] w_fb;
    logic [7:0] w_p0;
    logic [7:0] w_p1;
    logic [7:0] w_p2;
    logic [7:0] w_p3;

    assign w_fb = i_sym ^ r_r3;

    gf256_mult u_mul0 (.i_a(w_fb), .i_b(G0), .o_p(w_p0));
    gf256_mult u_mul1 (.i_a(w_fb), .i_b(G1), .o_p(w_p1));
    gf256_mult u_mul2 (.i_a(w_fb), .i_b(G2), .o_p(w_p2));
    gf256_mult u_mul3 (.i_a(w_fb), .i_b(G3), .o_p(w_p3));

    // Clear wins, then a message-symbol division step, then a parity shift-out
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_r0 <= 8'h00;
            r_r1 <= 8'h00;
            r_r2 <= 8'h00;
            r_r3 <= 8'h00;
        end else if (i_clear) begin
            r_r0 <= 8'h00;
            r_r1 <= 8'h00;
            r_r2 <= 8'h00;
            r_r3 <= 8'h00;
        end else if (i_load) begin
            r_r3 <= r_r2 ^ w_p3;
            r_r2 <= r_r1 ^ w_p2;
            r_r1 <= r_r0 ^ w_p1;
            r_r0 <= w_p0;
        end else if (i_shift) begin
            r_r3 <= r_r2;
            r_r2 <= r_r1;
            r_r1 <= r_r0;
            r_r0 <= 8'h00;
        end
    end

    assign o_r3 = r_r3;

endmodule

// File: rtl/rs_parity_enc.sv
// Systematic RS encoder: passes N_DATA symbols through, then emits 4 parity symbols.
module rs_parity_enc
    import rs_parity_enc_pkg::*;
#(
    parameter int N_DATA = 28
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_in_valid,
    input  logic [7:0] i_in_data,
    output logic       o_in_ready,
    output logic       o_out_valid,
    output logic [7:0] o_out_data,
    output logic       o_out_parity,
    output logic       o_out_last,
    input  logic       i_out_ready
);

    // Counter must also reach RS_NPAR-1 in the parity phase, even for tiny N_DATA
    localparam int CNT_W = ($clog2(N_DATA + 1) > 2) ? $clog2(N_DATA + 1) : 2;

    encState_t        r_state;
    encState_t        w_stateNext;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_load;
    logic             w_shift;
    logic             w_clear;
    logic             w_lastParity;
    logic [7:0]       w_r3;

    rs_lfsr4 u_lfsr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_clear (w_clear),
        .i_sym   (i_in_data),
        .o_r3    (w_r3)
    );

    assign w_lastParity = (r_cnt == CNT_W'(RS_NPAR - 1));

    // State and symbol counter registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_DATA;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Handshake, output mux and next-state logic; outputs forced low while in reset
    always_comb begin
        w_stateNext  = r_state;
        w_cntNext    = r_cnt;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_clear      = 1'b0;
        o_in_ready   = 1'b0;
        o_out_valid  = 1'b0;
        o_out_data   = 8'h00;
        o_out_parity = 1'b0;
        o_out_last   = 1'b0;
        if (!i_rst) begin
            case (r_state)
                ST_DATA: begin
                    o_out_valid = i_in_valid;
                    o_out_data  = i_in_data;
                    o_in_ready  = i_out_ready;
                    if (i_in_valid && i_out_ready) begin
                        w_load = 1'b1;
                        if (r_cnt == CNT_W'(N_DATA - 1)) begin
                            w_cntNext   = '0;
                            w_stateNext = ST_PARITY;
                        end else begin
                            w_cntNext = r_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    o_out_valid  = 1'b1;
                    o_out_parity = 1'b1;
                    o_out_data   = w_r3;
                    o_out_last   = w_lastParity;
                    if (i_out_ready) begin
                        if (w_lastParity) begin
                            w_clear     = 1'b1;
                            w_cntNext   = '0;
                            w_stateNext = ST_DATA;
                        end else begin
                            w_shift   = 1'b1;
                            w_cntNext = r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    w_stateNext = ST_DATA;
                    w_cntNext   = '0;
                end
            endcase
        end
    end

endmodule

// File: doc/rs_parity_enc.md
Name: rs_parity_enc

Overview:
- Systematic Reed-Solomon encoder over GF(256), field polynomial 0x11D, generator g(x) = (x+1)(x+α)(x+α²)(x+α³) = x⁴ + 0x0F·x³ + 0x36·x² + 0x78·x + 0x40.
- Encode-direction counterpart of the RS decoder datapath. Used to build CIRC C1 (32,28) / C2 (28,24) codewords for loopback test stimulus and for the encode path.
- Streams N_DATA message symbols through unchanged, then emits 4 parity symbols computed by an LFSR division.

Parameters:
- N_DATA, 28, message symbols per codeword. Legal range 1..251. Use 28 for C1, 24 for C2.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_in_valid  in  1  input symbol valid.
- i_in_data  in  8  input message symbol, first symbol = highest-degree coefficient.
- o_in_ready  out  1  encoder accepts the input symbol this cycle.
- o_out_valid  out  1  output symbol valid.
- o_out_data  out  8  codeword symbol.
- o_out_parity  out  1  current output symbol is a parity symbol.
- o_out_last  out  1  final (4th) parity symbol of the codeword.
- i_out_ready  in  1  downstream accepts the output symbol.

Behaviour:
- State: FSM {DATA, PARITY}, symbol counter cnt (width clog2(N_DATA+1)), remainder registers r0..r3 (8 bits each).
- Reset (async, i_rst=1): state=DATA, cnt=0, r0..r3=0x00. While reset is asserted, o_in_ready=0, o_out_valid=0, o_out_parity=0, o_out_last=0, o_out_data=0x00.
- DATA state, combinational pass-through with zero latency:
  - o_out_valid = i_in_valid
  - o_out_data = i_in_data
  - o_in_ready = i_out_ready
  - o_out_parity = 0, o_out_last = 0.
- DATA transfer: a transfer occurs when i_in_valid & i_out_ready. On a transfer:
  - f = i_in_data ^ r3
  - r3 ← r2 ^ f·0x0F
  - r2 ← r1 ^ f·0x36
  - r1 ← r0 ^ f·0x78
  - r0 ← f·0x40
  - cnt ← cnt+1
  - If this is transfer number N_DATA, then cnt ← 0 and state ← PARITY. The LFSR update above still applies to that last symbol.
- No transfer (either valid or ready low): all state holds.
- PARITY state:
  - o_in_ready = 0, o_out_valid = 1, o_out_parity = 1, o_out_data = r3.
  - o_out_last = 1 when cnt == 3.
- PARITY shift: when i_out_ready=1, r3←r2, r2←r1, r1←r0, r0←0x00, cnt←cnt+1. After the 4th accepted parity symbol: cnt←0, state←DATA, and r0..r3 are all 0x00 (guaranteed by the shift-in of zeros).
- Parity output order: coefficient of x³ first, x⁰ last.
- Back-to-back codewords: the first data symbol of the next codeword may be accepted in the cycle right after o_out_last is accepted. There are no idle cycles, so the throughput is one symbol per clock when both sides are always valid/ready.
- Stalls: i_out_ready low holds everything and o_out_data stays stable. Gaps in i_in_valid are allowed anywhere within the message.
- Reset mid-codeword: the partial codeword is discarded and the next input starts a fresh codeword.
- GF multiplies are by constants only. All additions are XOR. No carries; every value is 8 bits.

Decomposition:
- Shared package: GF_POLY = 0x11D, RS_NPAR = 4, generator coefficients G0..G3 = 0x40, 0x78, 0x36, 0x0F.
- Constant multipliers: reuse the existing gf256_mult, 4 instances with one operand tied to a Gn constant, and let synthesis fold them.
- One sub-module is natural: rs_lfsr4 (the remainder registers plus update/shift logic, with a load/shift/clear interface). The FSM and handshake stay in rs_parity_enc.

Test Plan:
1. N_DATA=28, 27×0x00 then 0x01, both sides always ready → 28 pass-through symbols, then parity 0x0F, 0x36, 0x78, 0x40. o_out_last is on 0x40. Total 32 cycles.
2. N_DATA=28, all-zero message → parity 0x00 ×4. Verify the codeword against a bench reference model: syndromes S0..S3 at α⁰..α³ are all zero.
3. Random messages, 100 back-to-back codewords, N_DATA=24 and 28 → every codeword has zero syndromes. No idle cycle between o_out_last and the next data symbol.
4. Random i_in_valid and i_out_ready toggling (50% each) → output sequence identical to the no-stall run. o_out_data stays stable while o_out_valid & !i_out_ready. o_in_ready is 0 throughout PARITY.
5. Assert i_rst after 10 data symbols, release, then send a fresh message → output equals a clean-run codeword. Outputs are 0 during reset.
6. N_DATA=1, single symbol 0x02 → output 0x02, then parity equal to 0x02·(0x0F, 0x36, 0x78, 0x40) = 0x1E, 0x6C, 0xF0, 0x80.
